// File: rtl/tsn_sched_pkg.sv
// Shared constants, FSM encoding and flat-index helper for the TSN dequeue scheduler.
package tsn_sched_pkg;

  localparam int unsigned NUM_PORTS  = 3;
  localparam int unsigned NUM_QUEUES = 8;
  localparam int unsigned PORT_W     = 2;
  localparam int unsigned QUEUE_W    = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  // Bit position of (port, queue) in the flat ready/gate vectors.
  function automatic int unsigned flat_idx(int unsigned port, int unsigned queue);
    return port * NUM_QUEUES + queue;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// 8-bit strict-priority encoder; the highest set bit wins.
module prio_enc8 (
  input  logic [7:0] req_i,
  output logic       hit_o,
  output logic [2:0] idx_o
);

  always_comb begin
    hit_o = |req_i;
    idx_o = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req_i[i]) idx_o = 3'(i);
    end
  end

endmodule

// File: rtl/tsn_dequeue_scheduler.sv
// Per-port egress scheduler: strict priority within a port, round-robin across ports,
// valid/ready dequeue request and per-port in-flight tracking.
module tsn_dequeue_scheduler
  import tsn_sched_pkg::*;
(
  input  logic                             clk_in,
  input  logic                             rst_n,
  input  logic [NUM_PORTS*NUM_QUEUES-1:0]  queue_o_rdy,
  input  logic [NUM_PORTS*NUM_QUEUES-1:0]  gate_open,
  output logic                             deq_vld,
  input  logic                             deq_rdy,
  output logic [PORT_W-1:0]                deq_port,
  output logic [QUEUE_W-1:0]               deq_queue,
  input  logic [NUM_PORTS-1:0]             tx_done,
  output logic [NUM_PORTS-1:0]             port_active
);

  state_e                 state_q, state_d;
  logic                   deq_vld_q, deq_vld_d;
  logic [PORT_W-1:0]      deq_port_q, deq_port_d;
  logic [QUEUE_W-1:0]     deq_queue_q, deq_queue_d;
  logic [PORT_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]   port_active_q, port_active_d;

  logic [NUM_PORTS-1:0]   port_hit;
  logic [QUEUE_W-1:0]     port_idx [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [NUM_QUEUES-1:0] elig;

    assign elig = queue_o_rdy[flat_idx(p, 0) +: NUM_QUEUES]
                & gate_open[flat_idx(p, 0) +: NUM_QUEUES]
                & {NUM_QUEUES{~port_active_q[p]}};

    prio_enc8 u_prio_enc (
      .req_i (elig),
      .hit_o (port_hit[p]),
      .idx_o (port_idx[p])
    );
  end

  logic               sel_found;
  logic [PORT_W-1:0]  sel_port;
  logic [QUEUE_W-1:0] sel_queue;

  // Search starts one past the last granted port and wraps modulo NUM_PORTS.
  always_comb begin
    sel_found = 1'b0;
    sel_port  = '0;
    sel_queue = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      int c;
      c = (int'(rr_ptr_q) + k) % NUM_PORTS;
      if (!sel_found && port_hit[c]) begin
        sel_found = 1'b1;
        sel_port  = PORT_W'(c);
        sel_queue = port_idx[c];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    deq_vld_d     = deq_vld_q;
    deq_port_d    = deq_port_q;
    deq_queue_d   = deq_queue_q;
    rr_ptr_d      = rr_ptr_q;
    port_active_d = port_active_q & ~tx_done;

    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          deq_vld_d   = 1'b1;
          deq_port_d  = sel_port;
          deq_queue_d = sel_queue;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (deq_rdy) begin
          deq_vld_d                 = 1'b0;
          port_active_d[deq_port_q] = 1'b1;
          rr_ptr_d                  = deq_port_q;
          state_d                   = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      deq_vld_q     <= 1'b0;
      deq_port_q    <= '0;
      deq_queue_q   <= '0;
      rr_ptr_q      <= PORT_W'(2);
      port_active_q <= '0;
    end else begin
      state_q       <= state_d;
      deq_vld_q     <= deq_vld_d;
      deq_port_q    <= deq_port_d;
      deq_queue_q   <= deq_queue_d;
      rr_ptr_q      <= rr_ptr_d;
      port_active_q <= port_active_d;
    end
  end

  assign deq_vld     = deq_vld_q;
  assign deq_port    = deq_port_q;
  assign deq_queue   = deq_queue_q;
  assign port_active = port_active_q;

endmodule

// File: tb/tb_tsn_dequeue_scheduler.sv
// Directed table-driven bench for tsn_dequeue_scheduler plus multi-cycle corner sequences.
module tb_tsn_dequeue_scheduler;

  logic        clk_in;
  logic        rst_n;
  logic [23:0] queue_o_rdy;
  logic [23:0] gate_open;
  logic        deq_vld;
  logic        deq_rdy;
  logic [1:0]  deq_port;
  logic [2:0]  deq_queue;
  logic [2:0]  tx_done;
  logic [2:0]  port_active;

  int n_chk  = 0;
  int n_fail = 0;

  tsn_dequeue_scheduler dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .queue_o_rdy (queue_o_rdy),
    .gate_open   (gate_open),
    .deq_vld     (deq_vld),
    .deq_rdy     (deq_rdy),
    .deq_port    (deq_port),
    .deq_queue   (deq_queue),
    .tx_done     (tx_done),
    .port_active (port_active)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst_n;
    logic [23:0] rdy;
    logic [23:0] gate;
    logic        drdy;
    logic [2:0]  txd;
    logic        vld;
    logic [1:0]  port;
    logic [2:0]  queue;
    logic [2:0]  act;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Waits (bounded) for deq_vld, sampling #1 after each rising edge.
  task automatic wait_vld(input string name, input int budget);
    int n;
    n = 0;
    while (deq_vld !== 1'b1 && n < budget) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    if (deq_vld !== 1'b1) chk({name, ".timeout"}, 0, 1);
  endtask

  initial begin
    int exp_seq[5];
    // {rst_n, rdy, gate, drdy, tx_done} -> {vld, port, queue, port_active} after the edge
    vecs[0]  = '{1'b0, 24'h000000, 24'h000000, 1'b0, 3'b000, 1'b0, 2'd0, 3'd0, 3'b000};
    vecs[1]  = '{1'b1, 24'h000000, 24'hFFFFFF, 1'b0, 3'b000, 1'b0, 2'd0, 3'd0, 3'b000};
    vecs[2]  = '{1'b1, 24'h000081, 24'hFFFFFF, 1'b0, 3'b000, 1'b1, 2'd0, 3'd7, 3'b000};
    vecs[3]  = '{1'b1, 24'h000081, 24'hFFFFFF, 1'b1, 3'b000, 1'b0, 2'd0, 3'd0, 3'b001};
    vecs[4]  = '{1'b1, 24'h008400, 24'hFF7FFF, 1'b0, 3'b000, 1'b1, 2'd1, 3'd2, 3'b001};
    vecs[5]  = '{1'b1, 24'h008400, 24'hFF7FFF, 1'b1, 3'b000, 1'b0, 2'd0, 3'd0, 3'b011};
    vecs[6]  = '{1'b1, 24'h000000, 24'hFFFFFF, 1'b0, 3'b011, 1'b0, 2'd0, 3'd0, 3'b000};
    vecs[7]  = '{1'b1, 24'h000000, 24'hFFFFFF, 1'b0, 3'b100, 1'b0, 2'd0, 3'd0, 3'b000};
    vecs[8]  = '{1'b1, 24'h000008, 24'hFFFFFF, 1'b1, 3'b000, 1'b1, 2'd0, 3'd3, 3'b000};
    vecs[9]  = '{1'b1, 24'h000008, 24'hFFFFFF, 1'b1, 3'b000, 1'b0, 2'd0, 3'd0, 3'b001};
    vecs[10] = '{1'b1, 24'h000008, 24'hFFFFFF, 1'b1, 3'b000, 1'b0, 2'd0, 3'd0, 3'b001};
    vecs[11] = '{1'b1, 24'h000008, 24'hFFFFFF, 1'b1, 3'b001, 1'b0, 2'd0, 3'd0, 3'b000};
    vecs[12] = '{1'b1, 24'h000008, 24'hFFFFFF, 1'b0, 3'b000, 1'b1, 2'd0, 3'd3, 3'b000};
    vecs[13] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 3'b000, 1'b1, 2'd0, 3'd3, 3'b000};
    vecs[14] = '{1'b1, 24'h000000, 24'hFFFFFF, 1'b0, 3'b000, 1'b1, 2'd0, 3'd3, 3'b000};
    vecs[15] = '{1'b1, 24'hFFFFFF, 24'h000000, 1'b0, 3'b000, 1'b1, 2'd0, 3'd3, 3'b000};
    vecs[16] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 3'b000, 1'b1, 2'd0, 3'd3, 3'b000};
    vecs[17] = '{1'b1, 24'h000000, 24'hFFFFFF, 1'b0, 3'b000, 1'b1, 2'd0, 3'd3, 3'b000};
    vecs[18] = '{1'b1, 24'h000000, 24'hFFFFFF, 1'b1, 3'b000, 1'b0, 2'd0, 3'd0, 3'b001};
    vecs[19] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 3'b000, 1'b1, 2'd1, 3'd7, 3'b001};
    vecs[20] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 3'b001, 1'b0, 2'd0, 3'd0, 3'b010};
    vecs[21] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 3'b000, 1'b1, 2'd2, 3'd7, 3'b010};
    vecs[22] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 3'b000, 1'b0, 2'd0, 3'd0, 3'b110};
    vecs[23] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 3'b000, 1'b1, 2'd0, 3'd7, 3'b110};
    vecs[24] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 3'b000, 1'b0, 2'd0, 3'd0, 3'b111};
    vecs[25] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 3'b000, 1'b0, 2'd0, 3'd0, 3'b111};
    vecs[26] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 3'b100, 1'b0, 2'd0, 3'd0, 3'b011};
    vecs[27] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 3'b000, 1'b1, 2'd2, 3'd7, 3'b011};

    rst_n = 1'b0; queue_o_rdy = '0; gate_open = '0; deq_rdy = 1'b0; tx_done = '0;
    #3;
    chk("reset.vld", int'(deq_vld), 0);
    chk("reset.active", int'(port_active), 0);

    for (int i = 0; i < NV; i++) begin
      rst_n       = vecs[i].rst_n;
      queue_o_rdy = vecs[i].rdy;
      gate_open   = vecs[i].gate;
      deq_rdy     = vecs[i].drdy;
      tx_done     = vecs[i].txd;
      @(posedge clk_in);
      #1;
      chk($sformatf("vec%0d.vld", i), int'(deq_vld), int'(vecs[i].vld));
      chk($sformatf("vec%0d.active", i), int'(port_active), int'(vecs[i].act));
      if (vecs[i].vld) begin
        chk($sformatf("vec%0d.port", i), int'(deq_port), int'(vecs[i].port));
        chk($sformatf("vec%0d.queue", i), int'(deq_queue), int'(vecs[i].queue));
      end
    end

    // Round-robin from reset with each port released right after its grant.
    tx_done = '0; deq_rdy = 1'b0; queue_o_rdy = '0;
    rst_n = 1'b0;
    #7;
    rst_n = 1'b1;
    queue_o_rdy = 24'hFFFFFF; gate_open = 24'hFFFFFF; deq_rdy = 1'b1;
    exp_seq = '{0, 1, 2, 0, 1};
    @(posedge clk_in);
    #1;
    for (int g = 0; g < 5; g++) begin
      wait_vld($sformatf("rr%0d", g), 10);
      chk($sformatf("rr%0d.port", g), int'(deq_port), exp_seq[g]);
      chk($sformatf("rr%0d.queue", g), int'(deq_queue), 7);
      @(posedge clk_in);
      #1;
      tx_done = 3'b001 << deq_port;
      @(posedge clk_in);
      #1;
      tx_done = '0;
    end

    // Async reset while a request is pending.
    deq_rdy = 1'b0;
    wait_vld("areset.pre", 10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.vld", int'(deq_vld), 0);
    chk("areset.active", int'(port_active), 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    @(posedge clk_in);
    #1;
    wait_vld("areset.post", 10);
    chk("areset.first_port", int'(deq_port), 0);
    chk("areset.first_queue", int'(deq_queue), 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
